// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, default widths and helpers for regfile_mp
package regfile_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_NUM_READ   = 4;
   localparam int DEF_NUM_WRITE  = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - bulk-clear sequencer: sweeps index 0..DEPTH-1, one entry per cycle
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int  DEPTH = 16,
   localparam int IW    = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_i,
   output logic          busy_o,
   output logic          clr_stb_o,
   output logic [IW-1:0] clr_idx_o,
   output logic          first_o
);

   clr_state_e    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      busy_o    = 1'b0;
      clr_stb_o = 1'b0;
      first_o   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clear_i) begin
               state_d = ST_CLEAR;
               idx_d   = '0;
            end
         end
         ST_CLEAR: begin
            busy_o    = 1'b1;
            clr_stb_o = 1'b1;
            first_o   = (idx_q == '0);
            if (idx_q == IW'(DEPTH - 1)) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   assign clr_idx_o = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with R0=0, port-priority writes and bulk clear
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_READ   = DEF_NUM_READ,
   parameter int NUM_WRITE  = DEF_NUM_WRITE
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_READ*ADDR_WIDTH-1:0]  regRead_i,
   output logic [NUM_READ*DATA_WIDTH-1:0]  dataRead_o,
   input  logic [NUM_WRITE-1:0]            writeEnable_i,
   input  logic [NUM_WRITE*ADDR_WIDTH-1:0] regWrite_i,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0] dataWrite_i,
   input  logic                           ovrflw_i,
   output logic                           ovrflw_o,
   input  logic                           clear_i,
   output logic                           busy_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic                  ovrflw_q, ovrflw_d;
   logic                  busy, clr_stb, clr_first;
   logic [ADDR_WIDTH-1:0] clr_idx;
   logic [NUM_WRITE-1:0]  wr_ok;

   regfile_clear_fsm #(.DEPTH(DEPTH)) u_clear_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (clear_i),
      .busy_o    (busy),
      .clr_stb_o (clr_stb),
      .clr_idx_o (clr_idx),
      .first_o   (clr_first)
   );

   assign wr_ok = writeEnable_i & {NUM_WRITE{~busy}};

   // Ascending port loop: a later (higher) port overwrites an earlier one on the same address.
   always_comb begin
      mem_d = mem_q;
      for (int k = 0; k < NUM_WRITE; k++) begin
         if (wr_ok[k] && (regWrite_i[k*ADDR_WIDTH +: ADDR_WIDTH] != '0))
            mem_d[regWrite_i[k*ADDR_WIDTH +: ADDR_WIDTH]] = dataWrite_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (clr_stb)
         mem_d[clr_idx] = '0;
      mem_d[0] = '0;
   end

   always_comb begin
      ovrflw_d = ovrflw_q;
      if (clr_first)
         ovrflw_d = 1'b0;
      else if (|wr_ok)
         ovrflw_d = ovrflw_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         ovrflw_q <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         ovrflw_q <= ovrflw_d;
      end
   end

   always_comb begin
      logic [ADDR_WIDTH-1:0] raddr;
      logic [DATA_WIDTH-1:0] rdata;
      raddr      = '0;
      rdata      = '0;
      dataRead_o = '0;
      for (int r = 0; r < NUM_READ; r++) begin
         raddr = regRead_i[r*ADDR_WIDTH +: ADDR_WIDTH];
         rdata = mem_q[raddr];
`ifdef REGFILE_BYPASS_EN
         for (int k = 0; k < NUM_WRITE; k++) begin
            if (wr_ok[k] && (regWrite_i[k*ADDR_WIDTH +: ADDR_WIDTH] == raddr))
               rdata = dataWrite_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
`endif
         if (raddr == '0)
            rdata = '0;
         dataRead_o[r*DATA_WIDTH +: DATA_WIDTH] = rdata;
      end
   end

   assign ovrflw_o = ovrflw_q;
   assign busy_o   = busy;

endmodule
